// File: rtl/vdma_rd_burst_engine_pkg.sv
// Shared types and constants for the VDMA read-burst engine.
// The state encoding stays a plain 2-bit vector so older netlists can still match it.
package SystemPkg;

    localparam int unsigned AXI_MAX_BURST = 256;

    typedef logic [1:0] RD_ENG_STATE;

    localparam RD_ENG_STATE S_IDLE   = 2'd0;
    localparam RD_ENG_STATE S_ISSUE  = 2'd1;
    localparam RD_ENG_STATE S_WAIT_R = 2'd2;
    localparam RD_ENG_STATE S_FSH    = 2'd3;

    // Returns the AXI arlen field (beats minus one) for the next sub-burst.
    function automatic logic [7:0] calcArlen(input int unsigned len, input int unsigned maxBurst);
        int unsigned beats;
        beats = (len > maxBurst) ? maxBurst : len;
        return 8'(beats - 1);
    endfunction

endpackage

// File: rtl/vdma_rd_burst_engine_rd_beat_counter.sv
// Counts R-channel handshakes of the current burst and compares the rlast position against arlen.
module rd_beat_counter
    import SystemPkg::*;
(
    input  logic       clock,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       beat,
    input  logic       rlast,
    input  logic [7:0] arlen,
    output logic       last_ok,
    output logic       last_err
);

    logic [8:0] r_count;
    logic       r_overrun;
    logic       w_atEnd;
    logic       w_over;

    assign w_atEnd  = (r_count == {1'b0, arlen});
    // The count saturates one past arlen, so an overrun is flagged only once per burst.
    assign w_over   = beat && !rlast && (r_count > {1'b0, arlen}) && !r_overrun;
    assign last_ok  = beat && rlast && w_atEnd;
    assign last_err = (beat && rlast && !w_atEnd) || w_over;

    always_ff @(posedge clock) begin
        if (!rst_n || clear) begin
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else if (beat) begin
            if (r_count <= {1'b0, arlen}) begin
                r_count <= r_count + 9'd1;
            end
            if (w_over) begin
                r_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vdma_rd_burst_engine.sv
// Turns read-FIFO burst/tail requests into AXI AR bursts of at most MAX_BURST beats.
// It also tracks the frame address, which restarts at base_addr on fsync.
module vdma_rd_burst_engine
    import SystemPkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_BYTES = 8,
    parameter int          LSIZE      = 9,
    parameter int unsigned MAX_BURST  = AXI_MAX_BURST
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              fsync,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              burst_req,
    input  logic              tail_req,
    input  logic [LSIZE-1:0]  req_len,
    output logic              resp,
    output logic              done,
    output logic              err,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    input  logic              rvalid,
    input  logic              rready,
    input  logic              rlast
);

    RD_ENG_STATE       r_state;
    logic [LSIZE-1:0]  r_remain;
    logic [ADDR_W-1:0] r_addr;
    logic              r_restartPend;
    logic              r_resp;
    logic              r_done;
    logic              r_err;
    logic              r_arvalid;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;

    logic              w_req;
    logic              w_arHs;
    logic              w_beat;
    logic              w_lastOk;
    logic              w_lastErr;
    logic              w_close;
    logic [8:0]        w_beats;
    logic [ADDR_W-1:0] w_step;
    logic [7:0]        w_reqArlen;
    logic [7:0]        w_remArlen;

    // burst_req and tail_req share req_len, so their priority only matters for naming.
    assign w_req      = burst_req || tail_req;
    assign w_arHs     = (r_state == S_ISSUE) && r_arvalid && arready;
    assign w_beat     = (r_state == S_WAIT_R) && rvalid && rready;
    assign w_close    = w_lastOk || (w_lastErr && rlast);
    assign w_beats    = {1'b0, r_arlen} + 9'd1;
    assign w_step     = ADDR_W'(w_beats) * ADDR_W'(DATA_BYTES);
    assign w_reqArlen = calcArlen(32'(req_len), MAX_BURST);
    assign w_remArlen = calcArlen(32'(r_remain), MAX_BURST);

    rd_beat_counter u_beatCounter (
        .clock    (clock),
        .rst_n    (rst_n),
        .clear    (w_arHs),
        .beat     (w_beat),
        .rlast    (rlast),
        .arlen    (r_arlen),
        .last_ok  (w_lastOk),
        .last_err (w_lastErr)
    );

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_remain      <= '0;
            r_addr        <= '0;
            r_restartPend <= 1'b0;
            r_resp        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_arlen       <= '0;
        end else begin
            r_resp <= 1'b0;
            r_done <= 1'b0;
            r_err  <= w_lastErr;
            if (fsync && (r_state == S_ISSUE || r_state == S_WAIT_R)) begin
                r_restartPend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (fsync) begin
                        r_addr <= base_addr;
                    end
                    // While done is still visible the controller has not yet dropped its request.
                    if (w_req && !r_done) begin
                        r_resp   <= 1'b1;
                        r_remain <= req_len;
                        if (req_len == '0) begin
                            r_state <= S_FSH;
                        end else begin
                            r_state   <= S_ISSUE;
                            r_arvalid <= 1'b1;
                            r_araddr  <= fsync ? base_addr : r_addr;
                            r_arlen   <= w_reqArlen;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_arHs) begin
                        r_arvalid <= 1'b0;
                        r_remain  <= r_remain - LSIZE'(w_beats);
                        r_addr    <= r_addr + w_step;
                        r_state   <= S_WAIT_R;
                    end
                end
                S_WAIT_R: begin
                    if (w_close) begin
                        if (r_remain != '0) begin
                            r_state   <= S_ISSUE;
                            r_arvalid <= 1'b1;
                            r_araddr  <= r_addr;
                            r_arlen   <= w_remArlen;
                        end else begin
                            r_state <= S_FSH;
                        end
                    end
                end
                S_FSH: begin
                    r_done        <= 1'b1;
                    r_state       <= S_IDLE;
                    r_restartPend <= 1'b0;
                    if (fsync || r_restartPend) begin
                        r_addr <= base_addr;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign resp    = r_resp;
    assign done    = r_done;
    assign err     = r_err;
    assign arvalid = r_arvalid;
    assign araddr  = r_araddr;
    assign arlen   = r_arlen;

endmodule

// File: tb/tb_vdma_rd_burst_engine.sv
// Directed self-checking bench for vdma_rd_burst_engine with hand-computed addresses and lengths.
module tb_vdma_rd_burst_engine;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        fsync;
    logic [31:0] base_addr;
    logic        burst_req;
    logic        tail_req;
    logic [8:0]  req_len;
    logic        resp;
    logic        done;
    logic        err;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid;
    logic        rready;
    logic        rlast;

    int assertCount = 0;
    int failCount   = 0;
    int respCnt     = 0;
    int doneCnt     = 0;
    int errCnt      = 0;
    int e0;
    int r0;

    vdma_rd_burst_engine #(
        .ADDR_W     (32),
        .DATA_BYTES (8),
        .LSIZE      (9),
        .MAX_BURST  (256)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .fsync     (fsync),
        .base_addr (base_addr),
        .burst_req (burst_req),
        .tail_req  (tail_req),
        .req_len   (req_len),
        .resp      (resp),
        .done      (done),
        .err       (err),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arlen     (arlen),
        .rvalid    (rvalid),
        .rready    (rready),
        .rlast     (rlast)
    );

    always #5 clock = ~clock;

    // Pulse counters sample registered outputs half a cycle after the active edge.
    always @(negedge clock) begin
        respCnt += int'(resp);
        doneCnt += int'(done);
        errCnt  += int'(err);
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached before end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic doFsync(input logic [31:0] base);
        base_addr = base;
        fsync     = 1'b1;
        @(negedge clock);
        fsync     = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input bit isTail, input logic [8:0] len, input bit hold);
        burst_req = !isTail;
        tail_req  = isTail;
        req_len   = len;
        @(negedge clock);
        checkOutput({tag, "_resp"}, 64'(resp), 64'd1);
        if (!hold) begin
            burst_req = 1'b0;
            tail_req  = 1'b0;
        end
    endtask

    task automatic acceptAr(input string tag, input logic [31:0] expAddr, input logic [7:0] expLen, input int stall);
        int n = 0;
        while (arvalid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput({tag, "_arvalid"}, 64'(arvalid), 64'd1);
        checkOutput({tag, "_araddr"}, 64'(araddr), 64'(expAddr));
        checkOutput({tag, "_arlen"}, 64'(arlen), 64'(expLen));
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            checkOutput({tag, "_stall_arvalid"}, 64'(arvalid), 64'd1);
            checkOutput({tag, "_stall_araddr"}, 64'(araddr), 64'(expAddr));
            checkOutput({tag, "_stall_arlen"}, 64'(arlen), 64'(expLen));
        end
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        checkOutput({tag, "_ardrop"}, 64'(arvalid), 64'd0);
    endtask

    task automatic sendBeats(input int count, input int lastIdx);
        for (int i = 0; i < count; i++) begin
            rvalid = 1'b1;
            rready = 1'b1;
            rlast  = (i == lastIdx);
            @(negedge clock);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic finishReq(input string tag);
        checkOutput({tag, "_done_early"}, 64'(done), 64'd0);
        @(negedge clock);
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
        @(negedge clock);
        checkOutput({tag, "_done_clear"}, 64'(done), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        fsync     = 1'b0;
        base_addr = '0;
        burst_req = 1'b0;
        tail_req  = 1'b0;
        req_len   = '0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rready    = 1'b0;
        rlast     = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_resp", 64'(resp), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_arvalid", 64'(arvalid), 64'd0);
        checkOutput("rst_araddr", 64'(araddr), 64'd0);
        checkOutput("rst_arlen", 64'(arlen), 64'd0);
        rst_n = 1'b1;
        @(negedge clock);

        // Single burst of 100 beats from 0x1000.
        doFsync(32'h1000);
        applyStimulus("t1", 1'b0, 9'd100, 1'b0);
        acceptAr("t1", 32'h1000, 8'd99, 0);
        e0 = errCnt;
        sendBeats(100, 99);
        finishReq("t1");
        checkOutput("t1_no_err", 64'(errCnt - e0), 64'd0);

        // 300 beats split into 256 + 44.
        doFsync(32'h1000);
        applyStimulus("t2", 1'b0, 9'd300, 1'b0);
        acceptAr("t2a", 32'h1000, 8'd255, 0);
        sendBeats(256, 255);
        checkOutput("t2_ar2_latency", 64'(arvalid), 64'd1);
        acceptAr("t2b", 32'h1800, 8'd43, 0);
        r0 = doneCnt;
        sendBeats(44, 43);
        finishReq("t2");
        checkOutput("t2_one_done", 64'(doneCnt - r0), 64'd1);

        // AR backpressure with the request held level.
        doFsync(32'h2000);
        r0 = respCnt;
        applyStimulus("t3", 1'b0, 9'd16, 1'b1);
        acceptAr("t3", 32'h2000, 8'd15, 5);
        burst_req = 1'b0;
        checkOutput("t3_resp_once", 64'(respCnt - r0), 64'd1);
        sendBeats(16, 15);
        finishReq("t3");

        // fsync during WAIT_R only takes effect after the request completes.
        doFsync(32'h1000);
        applyStimulus("t4", 1'b0, 9'd300, 1'b0);
        acceptAr("t4a", 32'h1000, 8'd255, 0);
        doFsync(32'h8000);
        sendBeats(256, 255);
        acceptAr("t4b", 32'h1800, 8'd43, 0);
        sendBeats(44, 43);
        finishReq("t4");
        applyStimulus("t4c", 1'b1, 9'd20, 1'b0);
        acceptAr("t4c", 32'h8000, 8'd19, 0);
        sendBeats(20, 19);
        finishReq("t4c");

        // rlast early on the 50th beat of a 100-beat burst.
        doFsync(32'h1000);
        applyStimulus("t5a", 1'b0, 9'd100, 1'b0);
        acceptAr("t5a", 32'h1000, 8'd99, 0);
        e0 = errCnt;
        sendBeats(50, 49);
        checkOutput("t5a_err_pulse", 64'(err), 64'd1);
        finishReq("t5a");
        checkOutput("t5a_err_count", 64'(errCnt - e0), 64'd1);

        // Overrun: arlen 3, rlast on beat index 6 -> one overrun pulse plus one rlast mismatch.
        applyStimulus("t5b", 1'b0, 9'd4, 1'b0);
        acceptAr("t5b", 32'h1320, 8'd3, 0);
        e0 = errCnt;
        sendBeats(7, 6);
        finishReq("t5b");
        checkOutput("t5b_err_count", 64'(errCnt - e0), 64'd2);

        // Zero-length request: resp then done, no AR.
        applyStimulus("t5c", 1'b0, 9'd0, 1'b0);
        checkOutput("t5c_no_ar", 64'(arvalid), 64'd0);
        @(negedge clock);
        checkOutput("t5c_done", 64'(done), 64'd1);
        checkOutput("t5c_still_no_ar", 64'(arvalid), 64'd0);
        @(negedge clock);

        // Reset in WAIT_R, stray beats afterwards, then a request coincident with fsync.
        doFsync(32'h1000);
        applyStimulus("t6", 1'b0, 9'd100, 1'b0);
        acceptAr("t6", 32'h1000, 8'd99, 0);
        sendBeats(10, -1);
        rst_n  = 1'b0;
        rvalid = 1'b1;
        rready = 1'b1;
        @(negedge clock);
        checkOutput("t6_rst_arvalid", 64'(arvalid), 64'd0);
        checkOutput("t6_rst_resp", 64'(resp), 64'd0);
        checkOutput("t6_rst_done", 64'(done), 64'd0);
        checkOutput("t6_rst_araddr", 64'(araddr), 64'd0);
        rst_n = 1'b1;
        e0 = errCnt;
        sendBeats(3, 2);
        @(negedge clock);
        checkOutput("t6_stray_no_err", 64'(errCnt - e0), 64'd0);
        base_addr = 32'h3000;
        fsync     = 1'b1;
        applyStimulus("t6b", 1'b0, 9'd8, 1'b0);
        fsync     = 1'b0;
        acceptAr("t6b", 32'h3000, 8'd7, 0);
        sendBeats(8, 7);
        finishReq("t6b");

        checkOutput("total_resp", 64'(respCnt), 64'd10);
        checkOutput("total_done", 64'(doneCnt), 64'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
